mmio_bus_master: RTL and testbench



---
 rtl/mmio_bus_master.sv | 141 ++++++++++++++
 tb/tb_mmio_bus_master.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_master.sv
// Single-outstanding initiator for the 64-bit MMIO bus: valid/ready request in, one-cycle response out.
// Optional address decode with error response is enabled by defining MMIO_DECODE_ERR_EN.
module mmio_bus_master #(
    parameter int unsigned WAIT_STATES = 0,
    parameter logic [7:0]  DEV_MIN     = 8'h01,
    parameter logic [7:0]  DEV_MAX     = 8'h05
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic [63:0] address,
    output logic        read,
    output logic        write,
    inout  wire  [63:0] data
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

`ifdef MMIO_DECODE_ERR_EN
    localparam bit DECODE_EN = 1'b1;
`else
    localparam bit DECODE_EN = 1'b0;
`endif

    logic [1:0]  state_q, state_d;
    logic        wr_q, wr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [63:0] address_q, address_d;
    logic        read_q, read_d;
    logic        write_q, write_d;
    logic        resp_valid_q, resp_valid_d;
    logic [63:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;
    logic        accept;
    logic        unmapped;

    assign req_ready  = (state_q == ST_IDLE);
    assign accept     = req_valid && req_ready;
    assign unmapped   = DECODE_EN && ((req_addr[63:56] < DEV_MIN) || (req_addr[63:56] > DEV_MAX));

    assign address    = address_q;
    assign read       = read_q;
    assign write      = write_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

    // Enable is decoded from state so an asynchronous reset releases the bus at once.
    assign data = ((state_q == ST_ACCESS) && wr_q) ? wdata_q : 'z;

    always_comb begin
        state_d      = state_q;
        wr_d         = wr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        address_d    = address_q;
        read_d       = 1'b0;
        write_d      = 1'b0;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    wr_d    = req_write;
                    wdata_d = req_wdata;
                    if (unmapped) begin
                        state_d      = ST_DONE;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = '0;
                    end else begin
                        state_d   = ST_SETUP;
                        address_d = req_addr;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
                cnt_d   = WAIT_STATES[3:0];
                read_d  = !wr_q;
                write_d = wr_q;
            end
            ST_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d      = ST_DONE;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    if (!wr_q) begin
                        resp_rdata_d = data;
                    end
                end else begin
                    cnt_d   = cnt_q - 4'd1;
                    read_d  = !wr_q;
                    write_d = wr_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            wr_q         <= 1'b0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            address_q    <= '0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_q         <= wr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            address_q    <= address_d;
            read_q       <= read_d;
            write_q      <= write_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

endmodule

// File: tb/tb_mmio_bus_master.sv
// Bench for mmio_bus_master: two instances (0 and 2 wait states), each on its own bus with a
// memory-like responder; a per-transaction timeline model derived from the bus rules checks every cycle.
module tb_mmio_bus_master;

    logic        clock = 1'b0;
    logic        reset;
    logic        fill;
    logic [1:0]  req_valid, req_write, req_ready, resp_valid, resp_err, rd, wr;
    logic [1:0][63:0] req_addr, req_wdata, resp_rdata, address;
    wire  [63:0] data0, data1;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [63:0] model_mem [2][16];
    logic [63:0] exp_rdata [2];
    logic [63:0] exp_addr  [2];

    localparam logic [63:0] SEG_ADDR = 64'h0500_0000_0000_0003;
    localparam logic [63:0] RELEASED = '1;

    always #5 clock = ~clock;

    // Released bus lines float high so a non-driving master is observable.
    pullup pu0 (data0);
    pullup pu1 (data1);

    mmio_bus_master #(.WAIT_STATES(0)) u_dut0 (
        .clock(clock), .reset(reset), .req_valid(req_valid[0]), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_ready(req_ready[0]),
        .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .resp_err(resp_err[0]),
        .address(address[0]), .read(rd[0]), .write(wr[0]), .data(data0)
    );

    mmio_bus_master #(.WAIT_STATES(2)) u_dut1 (
        .clock(clock), .reset(reset), .req_valid(req_valid[1]), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_ready(req_ready[1]),
        .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .resp_err(resp_err[1]),
        .address(address[1]), .read(rd[1]), .write(wr[1]), .data(data1)
    );

    function automatic logic [63:0] init_val(input int i);
        if (i == 0) return 64'hDEAD_BEEF;
        return 64'hA5A5_0000_0000_0000 ^ (64'(i) * 64'h0101_0101_0101_0101);
    endfunction

    // Responders: low address nibble selects a register; SEG_ADDR also mirrors into a seven-seg latch.
    logic [63:0] mem0 [16];
    logic [63:0] mem1 [16];
    logic [31:0] seg0, seg1;

    assign data0 = rd[0] ? mem0[address[0][3:0]] : 'z;
    assign data1 = rd[1] ? mem1[address[1][3:0]] : 'z;

    always @(posedge clock) begin
        if (fill) begin
            for (int i = 0; i < 16; i++) begin
                mem0[i] <= init_val(i);
                mem1[i] <= init_val(i);
            end
            seg0 <= '0;
            seg1 <= '0;
        end else begin
            if (wr[0]) begin
                mem0[address[0][3:0]] <= data0;
                if (address[0] == SEG_ADDR) seg0 <= data0[31:0];
            end
            if (wr[1]) begin
                mem1[address[1][3:0]] <= data1;
                if (address[1] == SEG_ADDR) seg1 <= data1[31:0];
            end
        end
    end

    function automatic logic [63:0] bus_data(input int idx);
        return (idx == 0) ? data0 : data1;
    endfunction

    function automatic bit is_mapped(input logic [63:0] a);
`ifdef MMIO_DECODE_ERR_EN
        return (a[63:56] >= 8'h01) && (a[63:56] <= 8'h05);
`else
        return (a[63:56] == a[63:56]);
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic start(input int idx, input bit w, input logic [63:0] a, input logic [63:0] d);
        check("ready_before_req", 64'(req_ready[idx]), 64'd1);
        req_valid[idx] = 1'b1;
        req_write[idx] = w;
        req_addr[idx]  = a;
        req_wdata[idx] = d;
    endtask

    // Follows one accepted request cycle by cycle; optionally keeps req_valid high with the next request.
    task automatic track(input int idx, input bit w, input logic [63:0] a, input logic [63:0] d,
                         input bit chain, input bit nw, input logic [63:0] na, input logic [63:0] nd);
        int   ws = idx * 2;
        logic [63:0] rexp = model_mem[idx][a[3:0]];
        bit   acc, done;
        logic [63:0] dexp;
        @(posedge clock);
        if (!is_mapped(a)) begin
            @(negedge clock);
            check("derr_resp_valid", 64'(resp_valid[idx]), 64'd1);
            check("derr_resp_err", 64'(resp_err[idx]), 64'd1);
            check("derr_rdata", resp_rdata[idx], 64'd0);
            check("derr_read", 64'(rd[idx]), 64'd0);
            check("derr_write", 64'(wr[idx]), 64'd0);
            check("derr_address", address[idx], exp_addr[idx]);
            check("derr_data", bus_data(idx), RELEASED);
            exp_rdata[idx] = '0;
            if (chain) begin
                req_write[idx] = nw; req_addr[idx] = na; req_wdata[idx] = nd;
            end else begin
                req_valid[idx] = 1'b0;
            end
            @(negedge clock);
            check("derr_ready_after", 64'(req_ready[idx]), 64'd1);
            check("derr_valid_after", 64'(resp_valid[idx]), 64'd0);
            return;
        end
        for (int k = 0; k <= 3 + ws; k++) begin
            @(negedge clock);
            if (k == 0) begin
                if (chain) begin
                    req_write[idx] = nw; req_addr[idx] = na; req_wdata[idx] = nd;
                end else begin
                    req_valid[idx] = 1'b0;
                end
            end
            acc  = (k >= 1) && (k <= 1 + ws);
            done = (k == 2 + ws);
            dexp = acc ? (w ? d : rexp) : RELEASED;
            check("read_strobe", 64'(rd[idx]), 64'(acc && !w));
            check("write_strobe", 64'(wr[idx]), 64'(acc && w));
            check("bus_address", address[idx], a);
            check("bus_data", bus_data(idx), dexp);
            check("resp_valid", 64'(resp_valid[idx]), 64'(done));
            check("req_ready", 64'(req_ready[idx]), 64'(k == 3 + ws));
            if (done) begin
                check("resp_err", 64'(resp_err[idx]), 64'd0);
                check("resp_rdata", resp_rdata[idx], w ? exp_rdata[idx] : rexp);
            end
        end
        if (w) model_mem[idx][a[3:0]] = d;
        else   exp_rdata[idx] = rexp;
        exp_addr[idx] = a;
    endtask

    initial begin
        logic [63:0] a, d;
        int idx;
        bit w;
        reset = 1'b1;
        fill  = 1'b1;
        req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < 16; j++) model_mem[i][j] = init_val(j);
            exp_rdata[i] = '0;
            exp_addr[i]  = '0;
        end
        repeat (3) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            check("rst_address", address[i], 64'd0);
            check("rst_read", 64'(rd[i]), 64'd0);
            check("rst_write", 64'(wr[i]), 64'd0);
            check("rst_resp_valid", 64'(resp_valid[i]), 64'd0);
            check("rst_resp_rdata", resp_rdata[i], 64'd0);
            check("rst_resp_err", 64'(resp_err[i]), 64'd0);
            check("rst_req_ready", 64'(req_ready[i]), 64'd1);
            check("rst_data", bus_data(i), RELEASED);
        end
        reset = 1'b0;
        fill  = 1'b0;
        @(negedge clock);

        // GPIO-style write with no wait states
        start(0, 1'b1, SEG_ADDR, 64'h1234);
        track(0, 1'b1, SEG_ADDR, 64'h1234, 1'b0, 1'b0, '0, '0);
        check("gpio_seg", 64'(seg0), 64'h1234);

        // Read with two wait states
        start(1, 1'b0, 64'h0500_0000_0000_0000, '0);
        track(1, 1'b0, 64'h0500_0000_0000_0000, '0, 1'b0, 1'b0, '0, '0);
        check("read_deadbeef", resp_rdata[1], 64'hDEAD_BEEF);

        // Back-to-back with req_valid held, on both instances
        for (int i = 0; i < 2; i++) begin
            start(i, 1'b1, 64'h0300_0000_0000_0007, 64'h0BAD_F00D_0000_0001);
            track(i, 1'b1, 64'h0300_0000_0000_0007, 64'h0BAD_F00D_0000_0001,
                  1'b1, 1'b0, 64'h0300_0000_0000_0007, '0);
            track(i, 1'b0, 64'h0300_0000_0000_0007, '0, 1'b0, 1'b0, '0, '0);
        end

        // Unmapped device byte: error response or full cycle depending on build
        start(0, 1'b0, 64'h0900_0000_0000_0000, '0);
        track(0, 1'b0, 64'h0900_0000_0000_0000, '0, 1'b0, 1'b0, '0, '0);
        check("unmapped_err_flag", 64'(resp_err[0]), 64'(!is_mapped(64'h0900_0000_0000_0000)));

        // Random mix of reads and writes across both instances
        for (int n = 0; n < 100; n++) begin
            idx = int'($urandom_range(0, 1));
            w   = 1'($urandom);
            a   = {8'($urandom_range(1, 5)), 52'h0, 4'($urandom)};
            d   = {$urandom, $urandom};
            start(idx, w, a, d);
            track(idx, w, a, d, 1'b0, 1'b0, '0, '0);
        end

        // Reset during the ACCESS phase of a write
        start(1, 1'b1, 64'h0400_0000_0000_000F, 64'h7777_6666_5555_4444);
        @(posedge clock);
        @(negedge clock);
        req_valid[1] = 1'b0;
        @(negedge clock);
        check("abort_write_before", 64'(wr[1]), 64'd1);
        reset = 1'b1;
        #1;
        check("abort_write_low", 64'(wr[1]), 64'd0);
        check("abort_data_released", data1, RELEASED);
        check("abort_ready", 64'(req_ready[1]), 64'd1);
        check("abort_address", address[1], 64'd0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("abort_no_resp", 64'(resp_valid[1]), 64'd0);
        end
        reset = 1'b0;
        exp_rdata[0] = '0; exp_rdata[1] = '0;
        exp_addr[0]  = '0; exp_addr[1]  = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check("post_abort_no_resp", 64'(resp_valid[1]), 64'd0);
            check("post_abort_ready", 64'(req_ready[1]), 64'd1);
            check("post_abort_address", address[1], 64'd0);
        end

        // Bus still works after the abort
        start(1, 1'b0, 64'h0200_0000_0000_0001, '0);
        track(1, 1'b0, 64'h0200_0000_0000_0001, '0, 1'b0, 1'b0, '0, '0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
